// File: rtl/sobel_window_gen.sv
// 3x3 window generator for the Sobel datapath: raster pixel stream in, one registered
// neighbourhood per centre out, with optional zero-padded borders and end-of-frame flush.
module sobel_window_gen #(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned IMG_W       = 256,
  parameter int unsigned IMG_H       = 256,
  parameter int unsigned BORDER_MODE = 0
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       Enable,
  input  logic [PIX_W-1:0]           DataIn,
  output logic                       in_ready,
  output logic [PIX_W-1:0]           win_0,
  output logic [PIX_W-1:0]           win_1,
  output logic [PIX_W-1:0]           win_2,
  output logic [PIX_W-1:0]           win_3,
  output logic [PIX_W-1:0]           win_4,
  output logic [PIX_W-1:0]           win_5,
  output logic [PIX_W-1:0]           win_6,
  output logic [PIX_W-1:0]           win_7,
  output logic [PIX_W-1:0]           win_8,
  output logic [$clog2(IMG_H)-1:0]   Out_Row,
  output logic [$clog2(IMG_W)-1:0]   Out_Column,
  output logic                       isReady,
  output logic                       isEnd
);

  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned FC_W  = $clog2(IMG_W + 2);
  localparam int unsigned DL    = 2 * IMG_W + 3;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_PEN  = ROW_W'(IMG_H - 2);
  localparam logic [COL_W-1:0] COL_PEN  = COL_W'(IMG_W - 2);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(IMG_W);

  typedef enum logic {LOAD, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  pcol_q, pcol_d;
  logic [ROW_W-1:0]  prow_q, prow_d;
  logic [COL_W-1:0]  ccol_q, ccol_d;
  logic [ROW_W-1:0]  crow_q, crow_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [PIX_W-1:0]  sr_q [DL];
  logic [PIX_W-1:0]  sr_d [DL];
  logic [PIX_W-1:0]  win_q [9];
  logic [PIX_W-1:0]  win_d [9];
  logic [PIX_W-1:0]  tap [9];
  logic [ROW_W-1:0]  orow_q, orow_d;
  logic [COL_W-1:0]  ocol_q, ocol_d;
  logic              ready_q, ready_d;
  logic              end_q, end_d;

  logic step, formed, emit, last_c, top, bot, lft, rgt, masked;

  always_comb begin
    state_d = state_q;
    pcol_d  = pcol_q;
    prow_d  = prow_q;
    ccol_d  = ccol_q;
    crow_d  = crow_q;
    fcnt_d  = fcnt_q;
    win_d   = win_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    ready_d = 1'b0;
    end_d   = 1'b0;
    masked  = 1'b0;

    step  = (state_q == FLUSH) || Enable;
    sr_d[0] = (state_q == FLUSH) ? '0 : DataIn;
    for (int unsigned i = 1; i < DL; i++) sr_d[i] = sr_q[i-1];

    // A centre exists once IMG_W+1 pixels of the frame have entered; flush steps always form one
    formed = (state_q == FLUSH) || (prow_q >= ROW_W'(2)) ||
             ((prow_q == ROW_W'(1)) && (pcol_q != '0));

    top = (crow_q == '0);
    bot = (crow_q == ROW_LAST);
    lft = (ccol_q == '0);
    rgt = (ccol_q == COL_LAST);

    for (int unsigned i = 0; i < 9; i++) begin
      masked = (BORDER_MODE != 0) &&
               (((i / 3) == 0 && top) || ((i / 3) == 2 && bot) ||
                ((i % 3) == 0 && lft) || ((i % 3) == 2 && rgt));
      tap[i] = masked ? '0 : sr_d[(2 - i / 3) * IMG_W + (2 - i % 3)];
    end

    if (BORDER_MODE != 0) begin
      emit   = 1'b1;
      last_c = bot && rgt;
    end else begin
      emit   = !top && !bot && !lft && !rgt;
      last_c = (crow_q == ROW_PEN) && (ccol_q == COL_PEN);
    end

    if (step) begin
      if (state_q == LOAD) begin
        if (pcol_q == COL_LAST) begin
          pcol_d = '0;
          prow_d = (prow_q == ROW_LAST) ? '0 : prow_q + 1'b1;
        end else begin
          pcol_d = pcol_q + 1'b1;
        end
      end

      if (formed) begin
        if (ccol_q == COL_LAST) begin
          ccol_d = '0;
          crow_d = (crow_q == ROW_LAST) ? '0 : crow_q + 1'b1;
        end else begin
          ccol_d = ccol_q + 1'b1;
        end
        if (emit) begin
          win_d   = tap;
          orow_d  = crow_q;
          ocol_d  = ccol_q;
          ready_d = 1'b1;
          end_d   = last_c;
        end
      end

      // Valid-only mode never forms the bottom-row centres, so rewind the centre count here
      if (state_q == LOAD) begin
        if ((prow_q == ROW_LAST) && (pcol_q == COL_LAST)) begin
          if (BORDER_MODE != 0) begin
            state_d = FLUSH;
            fcnt_d  = '0;
          end else begin
            crow_d = '0;
            ccol_d = '0;
          end
        end
      end else begin
        if (fcnt_q == FC_LAST) begin
          state_d = LOAD;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= LOAD;
      pcol_q  <= '0;
      prow_q  <= '0;
      ccol_q  <= '0;
      crow_q  <= '0;
      fcnt_q  <= '0;
      for (int unsigned i = 0; i < 9; i++) win_q[i] <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      ready_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcol_q  <= pcol_d;
      prow_q  <= prow_d;
      ccol_q  <= ccol_d;
      crow_q  <= crow_d;
      fcnt_q  <= fcnt_d;
      win_q   <= win_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      ready_q <= ready_d;
      end_q   <= end_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (step) sr_q <= sr_d;
  end

  assign in_ready   = (state_q == LOAD);
  assign win_0      = win_q[0];
  assign win_1      = win_q[1];
  assign win_2      = win_q[2];
  assign win_3      = win_q[3];
  assign win_4      = win_q[4];
  assign win_5      = win_q[5];
  assign win_6      = win_q[6];
  assign win_7      = win_q[7];
  assign win_8      = win_q[8];
  assign Out_Row    = orow_q;
  assign Out_Column = ocol_q;
  assign isReady    = ready_q;
  assign isEnd      = end_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench: two instances (valid-only and zero-pad) on a 4x3 image.
module tb_sobel_window_gen;
  localparam int W = 4;
  localparam int H = 3;

  typedef struct {
    logic [8:0][7:0] w;
    logic [1:0]      r;
    logic [1:0]      c;
    logic            e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic            en   [2];
  logic [7:0]      din  [2];
  logic            rdy  [2];
  logic [8:0][7:0] win  [2];
  logic [1:0]      orow [2];
  logic [1:0]      ocol [2];
  logic            ordy [2];
  logic            oend [2];

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;
  logic stepped [2];
  int lowcnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sobel_window_gen #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .BORDER_MODE(g)) u_dut (
      .CLK(clk), .Reset(rst), .Enable(en[g]), .DataIn(din[g]), .in_ready(rdy[g]),
      .win_0(win[g][0]), .win_1(win[g][1]), .win_2(win[g][2]),
      .win_3(win[g][3]), .win_4(win[g][4]), .win_5(win[g][5]),
      .win_6(win[g][6]), .win_7(win[g][7]), .win_8(win[g][8]),
      .Out_Row(orow[g]), .Out_Column(ocol[g]), .isReady(ordy[g]), .isEnd(oend[g]));
  end

  function automatic void push_exp(input int d, input int off, input int ncentres);
    exp_t x;
    int r, c, rr, cc;
    for (int k = 0; k < ncentres; k++) begin
      r = k / W;
      c = k % W;
      if (d == 0 && (r == 0 || r == H - 1 || c == 0 || c == W - 1)) continue;
      for (int t = 0; t < 9; t++) begin
        rr = r + t / 3 - 1;
        cc = c + t % 3 - 1;
        x.w[t] = (rr < 0 || rr >= H || cc < 0 || cc >= W) ? 8'd0 : 8'(off + rr * W + cc);
      end
      x.r = 2'(r);
      x.c = 2'(c);
      x.e = (d == 1) ? (k == W * H - 1) : (r == H - 2 && c == W - 2);
      if (d == 0) q0.push_back(x); else q1.push_back(x);
    end
  endfunction

  task automatic compare(input int d);
    exp_t x;
    checks++;
    if (!stepped[d]) begin
      errors++;
      $display("FAIL stall_emit dut%0d: isReady=1 after a cycle with no shift, want 0", d);
    end
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL extra_window dut%0d: got window (%0d,%0d), want none", d, orow[d], ocol[d]);
      return;
    end
    x = (d == 0) ? q0.pop_front() : q1.pop_front();
    checks++;
    if (win[d] !== x.w || orow[d] !== x.r || ocol[d] !== x.c || oend[d] !== x.e) begin
      errors++;
      $display("FAIL window dut%0d: got win=%h row=%0d col=%0d end=%b, want win=%h row=%0d col=%0d end=%b",
               d, win[d], orow[d], ocol[d], oend[d], x.w, x.r, x.c, x.e);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(negedge clk) begin
      if (rst) stepped[g] = 1'b0;
      else begin
        if (ordy[g]) compare(g);
        stepped[g] = !rdy[g] || en[g];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (!rdy[1]) lowcnt++;
      else if (lowcnt != 0) begin
        checks++;
        if (lowcnt != W + 1) begin
          errors++;
          $display("FAIL flush_len: in_ready low %0d cycles, want %0d", lowcnt, W + 1);
        end
        lowcnt = 0;
      end
    end
  end

  task automatic check_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (win[d] !== '0 || ordy[d] !== 1'b0 || oend[d] !== 1'b0 || rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset dut%0d: got win=%h rdy=%b end=%b in_ready=%b, want 0 0 0 1",
                 d, win[d], ordy[d], oend[d], rdy[d]);
      end
    end
  endtask

  task automatic send_px(input int d, input logic [7:0] v, input bit stall);
    int guard = 0;
    if (stall) begin
      while ($urandom_range(1, 0) == 1) begin
        en[d] = 1'b0;
        @(posedge clk); #1;
      end
    end
    while (!rdy[d]) begin
      en[d] = !stall;
      din[d] = 8'hEE;
      @(posedge clk); #1;
      guard++;
      if (guard > 50) begin
        errors++;
        $display("FAIL ready_timeout dut%0d: in_ready=0, want 1 within 50 cycles", d);
        return;
      end
    end
    en[d] = 1'b1;
    din[d] = v;
    @(posedge clk); #1;
    en[d] = 1'b0;
  endtask

  task automatic send_frame(input int d, input int off, input int n, input bit stall);
    for (int i = 0; i < n; i++) send_px(d, 8'(off + i), stall);
  endtask

  task automatic drain();
    int guard = 0;
    while ((q0.size() != 0 || q1.size() != 0 || !rdy[1]) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    en[0] = 1'b0; en[1] = 1'b0; din[0] = '0; din[1] = '0;
    #12 rst = 1'b1;
    #1 check_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    push_exp(0, 1, W * H);
    send_frame(0, 1, W * H, 1'b0);
    push_exp(1, 1, W * H);
    send_frame(1, 1, W * H, 1'b0);
    drain();

    for (int d = 0; d < 2; d++) begin
      push_exp(d, 1, W * H);
      send_frame(d, 1, W * H, 1'b1);
    end
    drain();

    for (int d = 0; d < 2; d++) begin
      push_exp(d, 1, 7 - (W + 1));
      send_frame(d, 1, 7, 1'b0);
    end
    drain();
    @(posedge clk); #3 rst = 1'b1;
    #1 check_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      push_exp(d, 1, W * H);
      send_frame(d, 1, W * H, 1'b0);
    end
    drain();

    for (int d = 0; d < 2; d++) begin
      push_exp(d, 1, W * H);
      push_exp(d, 100, W * H);
      send_frame(d, 1, W * H, 1'b0);
      send_frame(d, 100, W * H, 1'b0);
    end
    drain();

    for (int d = 0; d < 2; d++) begin
      checks++;
      if ((d == 0 ? q0.size() : q1.size()) != 0) begin
        errors++;
        $display("FAIL missing_windows dut%0d: %0d expected windows never emitted, want 0",
                 d, (d == 0 ? q0.size() : q1.size()));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
